ws2812_rx: RTL and testbench

- One-wire WS2812 receiver/decoder; the far end of the LED-strip pixel transmitter.
- Recovers 24-bit GRB pixel words from the serial pulse-width stream at 12 MHz (15 clk/bit).
- Detects the latch (reset) gap and reports pixel index and frame boundaries.
- Used as an on-board loopback checker and a bench monitor for the transmit path.

---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/ws2812_rx_sync.sv | 37 +++
 rtl/ws2812_rx.sv | 206 ++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 transmit and receive paths.
//   rx_state_t  receiver FSM states
//   grb_t       24-bit GRB pixel word (g in the top byte, sent first)
//   BITS_PER_PIXEL, PIXELS_PER_FRAME, CYCLES_PER_BIT, LATCH_CYCLES
package ws2812_pkg;

    localparam int BITS_PER_PIXEL   = 24;
    localparam int PIXELS_PER_FRAME = 64;
    localparam int CYCLES_PER_BIT   = 15;
    localparam int LATCH_CYCLES     = 600;

    typedef enum logic [1:0] {
        WAIT_LATCH,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: two-flop synchroniser for the asynchronous WS2812 line plus
// edge detection on the synchronised value. Runs on negedge clk like the rest
// of the receiver.
//   clk    system clock (falling edge active)
//   rst_n  asynchronous active-low reset
//   din    raw serial line
//   ds     synchronised line
//   rise   ds went 0->1 this cycle
//   fall   ds went 1->0 this cycle
module ws2812_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic ds,
    output logic rise,
    output logic fall
);

    logic s1, s2, prev;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign ds   = s2;
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 one-wire receiver. Measures high-pulse widths to recover
// MSB-first GRB pixel words, tracks pixel position within a frame and detects
// the latch gap that ends a frame. All logic runs on negedge clk.
//   clk          12 MHz system clock (falling edge active)
//   rst_n        asynchronous active-low reset
//   din          serial data line (asynchronous)
//   pixel_data   last decoded pixel, bit 23 = first bit received
//   pixel_valid  one-cycle pulse when pixel_data/pixel_index update
//   pixel_index  position of pixel_data in the current frame (wraps 63->0)
//   frame_done   one-cycle pulse at a latch following at least one pixel
//   frame_count  completed frames, wrapping
//   err_count    saturating error count (only with WS2812_RX_ERRCNT_EN)
//   error        one-cycle pulse on a protocol violation
// Optional feature macro: WS2812_RX_ERRCNT_EN adds err_count.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESH     = 6,
    parameter int MIN_HIGH       = 2,
    parameter int MAX_HIGH       = 12,
    parameter int LATCH_CYCLES   = ws2812_pkg::LATCH_CYCLES,
    parameter int BITS_PER_PIXEL = ws2812_pkg::BITS_PER_PIXEL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel_data,
    output logic                      pixel_valid,
    output logic [5:0]                pixel_index,
    output logic                      frame_done,
    output logic [4:0]                frame_count,
`ifdef WS2812_RX_ERRCNT_EN
    output logic [7:0]                err_count,
`endif
    output logic                      error
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int BW = $clog2(BITS_PER_PIXEL + 1);

    localparam logic [HW-1:0] H_SAT = HW'(MAX_HIGH + 1);
    localparam logic [HW-1:0] H_MIN = HW'(MIN_HIGH);
    localparam logic [HW-1:0] H_MAX = HW'(MAX_HIGH);
    localparam logic [HW-1:0] H_THR = HW'(BIT_THRESH);
    localparam logic [LW-1:0] L_SAT = LW'(LATCH_CYCLES);
    localparam logic [BW-1:0] B_FULL = BW'(BITS_PER_PIXEL);

    logic ds, rise, fall;

    ws2812_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .ds    (ds),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_t state, state_nx;

    logic [HW-1:0]             high_cnt;
    logic [LW-1:0]             low_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [5:0]                pix_cnt;
    logic                      px_seen;   // a pixel completed since the last latch
    logic [BITS_PER_PIXEL-1:0] shift_q;

    logic low_at_latch;
    logic do_shift, do_drop, do_latch, restart, err_pulse;

    assign low_at_latch = (low_cnt == L_SAT);

    // Run-length counters; both restart on the rising edge so high_cnt holds
    // the full pulse width when the falling edge arrives.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt <= '0;
            low_cnt  <= '0;
        end else begin
            if (rise)
                high_cnt <= HW'(1);
            else if (ds && high_cnt != H_SAT)
                high_cnt <= high_cnt + HW'(1);

            if (rise)
                low_cnt <= '0;
            else if (!ds && low_cnt != L_SAT)
                low_cnt <= low_cnt + LW'(1);
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_LATCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_shift  = 1'b0;
        do_drop   = 1'b0;
        do_latch  = 1'b0;
        restart   = 1'b0;
        err_pulse = 1'b0;
        case (state)
            WAIT_LATCH: begin
                if (low_at_latch) begin
                    restart  = 1'b1;
                    state_nx = rise ? HIGH : IDLE;
                end
            end
            IDLE: begin
                if (rise) state_nx = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    if (high_cnt < H_MIN) begin
                        err_pulse = 1'b1;
                        state_nx  = LOW;
                    end else if (high_cnt > H_MAX) begin
                        err_pulse = 1'b1;
                        do_drop   = 1'b1;
                        state_nx  = WAIT_LATCH;
                    end else begin
                        do_shift  = 1'b1;
                        state_nx  = LOW;
                    end
                end
            end
            LOW: begin
                // A gap of exactly LATCH_CYCLES can end on the same cycle as the
                // next rising edge; latch first, then follow the new pulse.
                if (low_at_latch) begin
                    do_latch  = 1'b1;
                    err_pulse = (bit_cnt != '0);
                    state_nx  = rise ? HIGH : IDLE;
                end else if (rise) begin
                    state_nx = HIGH;
                end
            end
            default: state_nx = WAIT_LATCH;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            px_seen     <= 1'b0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            error       <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= err_pulse;

            if (do_shift) begin
                shift_q <= {shift_q[BITS_PER_PIXEL-2:0], (high_cnt >= H_THR)};
                bit_cnt <= bit_cnt + BW'(1);
            end else if (bit_cnt == B_FULL) begin
                // Publish one cycle after the last bit lands in the shifter.
                pixel_data  <= shift_q;
                pixel_valid <= 1'b1;
                pixel_index <= pix_cnt;
                pix_cnt     <= pix_cnt + 6'd1;
                px_seen     <= 1'b1;
                bit_cnt     <= '0;
            end

            if (do_drop)
                bit_cnt <= '0;

            if (do_latch) begin
                bit_cnt <= '0;
                pix_cnt <= '0;
                px_seen <= 1'b0;
                if (px_seen) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 5'd1;
                end
            end

            // Leaving WAIT_LATCH starts a fresh frame.
            if (restart) begin
                bit_cnt <= '0;
                pix_cnt <= '0;
                px_seen <= 1'b0;
            end
        end
    end

`ifdef WS2812_RX_ERRCNT_EN
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (err_pulse && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
module tb_ws2812_rx;

    logic        clk, rst_n, din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [5:0]  pixel_index;
    logic        frame_done;
    logic [4:0]  frame_count;
    logic        error;
`ifdef WS2812_RX_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    ws2812_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .frame_count (frame_count),
`ifdef WS2812_RX_ERRCNT_EN
        .err_count   (err_count),
`endif
        .error       (error)
    );

    initial clk = 1'b0;
    always #42 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Observed events (sampled on posedge, away from the active negedge)
    logic [23:0] got_data[$];
    logic [5:0]  got_idx[$];
    int n_fd = 0, n_err = 0, n_coinc = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (pixel_valid) begin
                got_data.push_back(pixel_data);
                got_idx.push_back(pixel_index);
            end
            if (frame_done) n_fd++;
            if (error) n_err++;
            if (pixel_valid && error) n_coinc++;
        end
    end

    // Reference model: frame-level bookkeeping from the protocol rules
    logic [23:0] exp_data[$];
    logic [5:0]  exp_idx[$];
    int m_pix = 0, m_fd = 0, m_err = 0, m_frames = 0, m_errcnt = 0;
    logic [23:0] m_last_data = '0;
    logic [5:0]  m_last_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_error();
        m_err++;
        if (m_errcnt < 255) m_errcnt++;
    endtask

    task automatic exp_pixel(input logic [23:0] v);
        exp_data.push_back(v);
        exp_idx.push_back(6'(m_pix % 64));
        m_last_data = v;
        m_last_idx  = 6'(m_pix % 64);
        m_pix++;
    endtask

    task automatic exp_latch(input bit partial);
        if (partial) m_error();
        if (m_pix > 0) begin
            m_fd++;
            m_frames++;
        end
        m_pix = 0;
    endtask

    task automatic hi(input int n);
        din = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic lo(input int n);
        din = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input bit b);
        hi(b ? int'($urandom_range(12, 6)) : int'($urandom_range(5, 2)));
        lo(int'($urandom_range(8, 4)));
    endtask

    task automatic send_bits(input logic [23:0] v, input int from, input int to);
        for (int i = from; i >= to; i--) send_bit(v[i]);
    endtask

    task automatic check_step(input string tag);
        chk({tag, "_npix"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            chk({tag, "_data"}, got_data[i], exp_data[i]);
            chk({tag, "_idx"}, got_idx[i], exp_idx[i]);
        end
        got_data.delete();
        got_idx.delete();
        exp_data.delete();
        exp_idx.delete();
        chk({tag, "_frame_done"}, n_fd, m_fd);
        chk({tag, "_errors"}, n_err, m_err);
        chk({tag, "_frame_count"}, frame_count, m_frames % 32);
        chk({tag, "_hold_data"}, pixel_data, m_last_data);
        chk({tag, "_hold_idx"}, pixel_index, m_last_idx);
`ifdef WS2812_RX_ERRCNT_EN
        chk({tag, "_err_count"}, err_count, m_errcnt);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, pixel_data, 0);
        chk({tag, "_valid"}, pixel_valid, 0);
        chk({tag, "_idx"}, pixel_index, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_fc"}, frame_count, 0);
        chk({tag, "_err"}, error, 0);
`ifdef WS2812_RX_ERRCNT_EN
        chk({tag, "_errcnt"}, err_count, 0);
`endif
    endtask

    initial begin
        #(84 * 150000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] v;
        logic [23:0] pk;

        // Reset state
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        rst_n = 1'b1;

        // Power-up mid-stream: pulses ignored until the first latch gap
        v = 24'($urandom);
        send_bits(v, 23, 12);
        hi(20);
        lo(3);
        send_bits(v, 11, 4);
        lo(10);
        check_step("powerup_quiet");
        lo(700);
        pk = 24'hA53C0F;
        send_bits(pk, 23, 0);
        exp_pixel(pk);
        lo(10);
        check_step("first_pixel");
        lo(620);
        exp_latch(1'b0);
        check_step("first_latch");

        // Full 64-pixel frame
        for (int i = 0; i < 64; i++) begin
            v = {18'($urandom), 6'(i)};
            send_bits(v, 23, 0);
            exp_pixel(v);
        end
        lo(620);
        exp_latch(1'b0);
        check_step("frame64");

        // 65 pixels: index wraps to 0 on the 65th
        for (int i = 0; i < 65; i++) begin
            v = 24'($urandom);
            send_bits(v, 23, 0);
            exp_pixel(v);
        end
        lo(620);
        exp_latch(1'b0);
        check_step("frame65");

        // Pulse-width boundaries: 1s at 12 high, 0s at 2 high
        v = 24'($urandom);
        for (int i = 23; i >= 0; i--) begin
            hi(v[i] ? 12 : 2);
            lo(5);
        end
        exp_pixel(v);
        lo(10);
        check_step("width_edges");

        // One-cycle glitch between bits
        v = 24'($urandom);
        send_bits(v, 23, 14);
        hi(1);
        lo(6);
        m_error();
        send_bits(v, 13, 0);
        exp_pixel(v);
        lo(10);
        check_step("glitch");
        lo(620);
        exp_latch(1'b0);
        check_step("glitch_latch");

        // Over-long pulse mid-pixel: resync required before decoding again
        v = 24'($urandom);
        send_bits(v, 23, 16);
        hi(20);
        lo(6);
        m_error();
        m_pix = 0;
        send_bits(24'($urandom), 23, 0);
        lo(10);
        check_step("long_pulse");
        lo(700);
        v = 24'($urandom);
        send_bits(v, 23, 0);
        exp_pixel(v);
        lo(620);
        exp_latch(1'b0);
        check_step("long_resync");

        // Just-over-limit pulse (13 cycles) is also a protocol error
        send_bits(24'($urandom), 23, 20);
        hi(13);
        lo(6);
        m_error();
        m_pix = 0;
        lo(700);
        check_step("pulse13");

        // Partial pixel at latch: error, no frame_done
        send_bits(24'($urandom), 23, 14);
        lo(620);
        exp_latch(1'b1);
        check_step("partial_latch");

        // Reset mid-frame
        send_bits(24'($urandom), 23, 14);
        din   = 1'b1;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge clk);
        din   = 1'b0;
        rst_n = 1'b1;
        m_pix = 0;
        m_frames = 0;
        m_errcnt = 0;
        m_last_data = '0;
        m_last_idx  = '0;
        send_bits(24'($urandom), 23, 0);
        lo(10);
        check_step("after_reset_quiet");
        lo(700);
        v = 24'($urandom);
        send_bits(v, 23, 0);
        exp_pixel(v);
        lo(620);
        exp_latch(1'b0);
        check_step("after_reset_frame");

        chk("valid_error_coincide", n_coinc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
